id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register of the 5-stage MIPS pipeline. It sits directly

---
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, WB bypass, flush squash and
// saturating stall/flush counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_write_en,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [3:0]        ex_alu_op,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              load_use;
  logic              bubble;
  logic [DATA_W-1:0] op_a_sel;
  logic [DATA_W-1:0] op_b_sel;

  // A load in EX whose target feeds the ID instruction cannot be forwarded in time.
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign hazard_stall = load_use && !flush;
  assign bubble       = flush || load_use;

  // The regfile writes on the same edge we capture, so WB data must bypass the read port.
  always_comb begin
    op_a_sel = id_rdata1;
    if (id_rs == '0)
      op_a_sel = '0;
    else if (wb_write_en && (wb_rd == id_rs))
      op_a_sel = wb_write_data;

    op_b_sel = id_rdata2;
    if (id_rt == '0)
      op_b_sel = '0;
    else if (wb_write_en && (wb_rd == id_rt))
      op_b_sel = wb_write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_alu_op    <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (bubble) begin
      // Datapath fields hold; only the valid/side-effect bits matter for a bubble.
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_op_a      <= op_a_sel;
      ex_op_b      <= op_b_sel;
      ex_imm       <= id_imm;
      ex_alu_op    <= id_alu_op;
      ex_reg_write <= id_reg_write && id_valid;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_mem_write <= id_mem_write && id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard_stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - Table-driven scoreboard bench for id_ex_stage (16-bit and 2-bit counter instances).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm, wb_write_data;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, wb_write_en, flush;

  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  logic [3:0]  ex_alu_op;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_hazard_stall, s_ex_valid, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [31:0] s_ex_op_a, s_ex_op_b, s_ex_imm;
  logic [3:0]  s_ex_alu_op;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .wb_rd(wb_rd), .wb_write_en(wb_write_en), .wb_write_data(wb_write_data), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .wb_rd(wb_rd), .wb_write_en(wb_write_en), .wb_write_data(wb_write_data), .flush(flush),
    .hazard_stall(s_hazard_stall), .ex_valid(s_ex_valid), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
    .ex_rd(s_ex_rd), .ex_op_a(s_ex_op_a), .ex_op_b(s_ex_op_b), .ex_imm(s_ex_imm),
    .ex_alu_op(s_ex_alu_op), .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
    .ex_mem_write(s_ex_mem_write), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs, rt, rd; logic [31:0] r1, r2, imm; logic [3:0] op;
    logic rw, mr, mw; logic we; logic [4:0] wrd; logic [31:0] wd; logic fl;
    logic e_stall; logic e_valid; logic [31:0] e_a, e_b;
  } vec_t;

  typedef struct {
    logic valid, rw, mr, mw, ck; logic [4:0] rs, rt, rd; logic [31:0] a, b, imm; logic [3:0] op;
    logic [15:0] sc, fc; logic [1:0] ssc, sfc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        m_valid, m_mr;
  logic [4:0]  m_rd;
  logic [15:0] m_sc, m_fc;
  logic [1:0]  m_ssc, m_sfc;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs, rt, rd,
                              input logic [31:0] r1, r2, input logic rw, mr,
                              input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic fl, input logic es, ev, input logic [31:0] ea, eb);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.rd = rd; x.r1 = r1; x.r2 = r2;
    x.imm = (r1 ^ 32'h5A5A_0000) | {27'd0, rd}; x.op = rd[3:0];
    x.rw = rw; x.mr = mr; x.mw = !rw && v;
    x.we = we; x.wrd = wrd; x.wd = wd; x.fl = fl;
    x.e_stall = es; x.e_valid = ev; x.e_a = ea; x.e_b = eb;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    id_rdata1 = x.r1; id_rdata2 = x.r2; id_imm = x.imm; id_alu_op = x.op;
    id_reg_write = x.rw; id_mem_read = x.mr; id_mem_write = x.mw;
    wb_write_en = x.we; wb_rd = x.wrd; wb_write_data = x.wd; flush = x.fl;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_mr = 1'b0; m_rd = '0;
    m_sc = '0; m_fc = '0; m_ssc = '0; m_sfc = '0;
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".stall"}, hazard_stall, 0);
    chk({tag, ".ex_valid"}, ex_valid, 0);
    chk({tag, ".ctrl"}, {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    chk({tag, ".regs"}, {ex_rs, ex_rt, ex_rd, ex_alu_op}, 0);
    chk({tag, ".op_a"}, ex_op_a, 0);
    chk({tag, ".op_b"}, ex_op_b, 0);
    chk({tag, ".imm"}, ex_imm, 0);
    chk({tag, ".cnts"}, {stall_cnt, flush_cnt}, 0);
    chk({tag, ".small_cnts"}, {s_stall_cnt, s_flush_cnt}, 0);
  endtask

  // Drive one ID-cycle, check the combinational stall, then compare the captured EX state.
  task automatic step(input vec_t x, input string tag);
    logic lu, st, bub;
    exp_t e;
    drive(x);
    #1;
    lu  = m_valid && m_mr && (m_rd != 0) && x.v && ((m_rd == x.rs) || (m_rd == x.rt));
    st  = lu && !x.fl;
    bub = x.fl || lu;
    chk({tag, ".hazard_stall"}, hazard_stall, x.e_stall);
    chk({tag, ".small_stall"}, s_hazard_stall, x.e_stall);
    e.valid = x.e_valid; e.ck = !bub;
    e.rw = !bub && x.rw && x.v; e.mr = !bub && x.mr && x.v; e.mw = !bub && x.mw && x.v;
    e.rs = x.rs; e.rt = x.rt; e.rd = x.rd; e.a = x.e_a; e.b = x.e_b; e.imm = x.imm; e.op = x.op;
    if (st && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    if (x.fl && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    if (st && m_ssc != 2'b11) m_ssc = m_ssc + 2'd1;
    if (x.fl && m_sfc != 2'b11) m_sfc = m_sfc + 2'd1;
    e.sc = m_sc; e.fc = m_fc; e.ssc = m_ssc; e.sfc = m_sfc;
    m_valid = !bub && x.v;
    m_mr = e.mr;
    if (!bub) m_rd = x.rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.scoreboard: got empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ex_valid"}, ex_valid, e.valid);
      chk({tag, ".small_valid"}, s_ex_valid, e.valid);
      chk({tag, ".ctrl"}, {ex_reg_write, ex_mem_read, ex_mem_write}, {e.rw, e.mr, e.mw});
      chk({tag, ".stall_cnt"}, stall_cnt, e.sc);
      chk({tag, ".flush_cnt"}, flush_cnt, e.fc);
      chk({tag, ".small_stall_cnt"}, s_stall_cnt, e.ssc);
      chk({tag, ".small_flush_cnt"}, s_flush_cnt, e.sfc);
      if (e.ck) begin
        chk({tag, ".regs"}, {ex_rs, ex_rt, ex_rd, ex_alu_op}, {e.rs, e.rt, e.rd, e.op});
        chk({tag, ".op_a"}, ex_op_a, e.a);
        chk({tag, ".op_b"}, ex_op_b, e.b);
        chk({tag, ".imm"}, ex_imm, e.imm);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t ld, dep, nop;

    // lw $3 / add $4,$3,$5 / bypass / $0 / flush+load-use / invalid ID / ex_rd=0 / rt-hazard
    tbl.push_back(mk(1, 1, 3, 3, 'h100, 0, 1, 1, 0, 0, 0, 0, 0, 1, 'h100, 0));
    tbl.push_back(mk(1, 3, 5, 4, 0, 'h50, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 5, 4, 0, 'h50, 1, 0, 1, 3, 'h33, 0, 0, 1, 'h33, 'h50));
    tbl.push_back(mk(1, 7, 8, 9, 'h11, 'h22, 1, 0, 1, 7, 'hABCD, 0, 0, 1, 'hABCD, 'h22));
    tbl.push_back(mk(1, 9, 0, 2, 'h99, 'hDEAD, 0, 0, 1, 0, 'h55, 0, 0, 1, 'h99, 0));
    tbl.push_back(mk(1, 0, 2, 6, 'h77, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(1, 2, 3, 7, 'h12, 'h13, 1, 0, 0, 2, 'hFF, 0, 0, 1, 'h12, 'h13));
    tbl.push_back(mk(1, 1, 6, 6, 'h200, 0, 1, 1, 0, 0, 0, 0, 0, 1, 'h200, 0));
    tbl.push_back(mk(1, 6, 1, 10, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 1, 11, 'h44, 1, 1, 1, 0, 0, 0, 0, 0, 0, 'h44, 1));
    tbl.push_back(mk(1, 1, 5, 5, 'h300, 0, 1, 1, 0, 0, 0, 0, 0, 1, 'h300, 0));
    tbl.push_back(mk(0, 5, 5, 12, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 5, 5));
    tbl.push_back(mk(1, 1, 0, 0, 'h400, 0, 1, 1, 0, 0, 0, 0, 0, 1, 'h400, 0));
    tbl.push_back(mk(1, 0, 0, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 2, 5, 'h500, 3, 1, 1, 0, 0, 0, 0, 0, 1, 'h500, 3));
    tbl.push_back(mk(1, 2, 5, 14, 6, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 5, 14, 6, 7, 1, 0, 0, 0, 0, 0, 0, 1, 6, 7));

    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop.mw = 1'b0;
    drive(nop);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // Three more load-use hazards: the 2-bit counter must stick at 3.
    ld  = mk(1, 1, 3, 3, 'h10, 0, 1, 1, 0, 0, 0, 0, 0, 1, 'h10, 0);
    dep = mk(1, 3, 3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(ld, $sformatf("sat_ld%0d", i));
      step(dep, $sformatf("sat_dep%0d", i));
      dep.e_stall = 1'b0; dep.e_valid = 1'b1; dep.e_a = 1; dep.e_b = 1;
      step(dep, $sformatf("sat_re%0d", i));
      dep.e_stall = 1'b1; dep.e_valid = 1'b0; dep.e_a = 0; dep.e_b = 0;
    end
    nop.fl = 1'b1;
    for (int i = 0; i < 3; i++)
      step(nop, $sformatf("sat_flush%0d", i));
    nop.fl = 1'b0;

    // Asynchronous reset asserted mid-cycle while a load-use stall is active.
    step(ld, "mid_ld");
    drive(dep);
    #1;
    chk("mid.stall_before_reset", hazard_stall, 1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    dep.e_stall = 1'b0; dep.e_valid = 1'b1; dep.e_a = 1; dep.e_b = 1;
    step(dep, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
